// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace capture logic analyzer.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        POST    = 2'd1,
        DUMP    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [7:0]  FRAME_SYNC   = 8'hA5;
    localparam int unsigned HEADER_BYTES = 3;

    // Bytes needed to carry one sample of the given bit width.
    function automatic int unsigned entry_bytes(input int unsigned width_bits);
        return (width_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port.
module sram_1r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-cycle tx_en handshake; line idles high.
module uart_transmit (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] clocks_per_bit,
    input  logic        tx_en,
    input  logic [7:0]  tx_char,
    output logic        tx_ready,
    output logic        uart_tx
);

    logic [8:0]  shift_q;
    logic [3:0]  bits_left_q;
    logic [11:0] baud_q;
    logic        ready_q;
    logic        tx_q;

    // Start bit on load, then eight data bits LSB first, then the stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bits_left_q <= '0;
            baud_q      <= '0;
            ready_q     <= 1'b1;
            tx_q        <= 1'b1;
        end else if (ready_q) begin
            if (tx_en) begin
                shift_q     <= {1'b1, tx_char};
                bits_left_q <= 4'd9;
                baud_q      <= clocks_per_bit - 12'd1;
                ready_q     <= 1'b0;
                tx_q        <= 1'b0;
            end
        end else if (baud_q != 12'd0) begin
            baud_q <= baud_q - 12'd1;
        end else if (bits_left_q == 4'd0) begin
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
        end else begin
            tx_q        <= shift_q[0];
            shift_q     <= {1'b1, shift_q[8:1]};
            bits_left_q <= bits_left_q - 4'd1;
            baud_q      <= clocks_per_bit - 12'd1;
        end
    end

    assign tx_ready = ready_q;
    assign uart_tx  = tx_q;

endmodule

// File: rtl/trace_capture_uart.sv
// Circular trace buffer with trigger, post-trigger window and UART dump of
// the captured entries (header, entry count, entries oldest-first).
module trace_capture_uart
    import trace_capture_pkg::*;
#(
    parameter int unsigned CAPTURE_WIDTH_BITS   = 32,
    parameter int unsigned CAPTURE_SIZE         = 64,
    parameter int unsigned POST_TRIGGER_ENTRIES = 16,
    parameter int unsigned CLOCKS_PER_BIT       = 54
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CAPTURE_WIDTH_BITS-1:0] capture_data,
    input  logic                          capture_enable,
    input  logic                          trigger,
    input  logic                          rearm,
    output logic                          uart_tx,
    output logic                          triggered,
    output logic                          dump_active,
    output logic                          dump_done
);

    localparam int unsigned AW   = (CAPTURE_SIZE > 1) ? $clog2(CAPTURE_SIZE) : 1;
    localparam int unsigned EB   = entry_bytes(CAPTURE_WIDTH_BITS);
    localparam int unsigned BIW  = (EB > 1) ? $clog2(EB) : 1;
    localparam int unsigned PADW = EB * 8;
    localparam int unsigned PCW  = $clog2(POST_TRIGGER_ENTRIES + 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic                    wrapped_q, wrapped_d;
    logic [PCW-1:0]          post_cnt_q, post_cnt_d;
    logic                    triggered_q, triggered_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             ent_left_q, ent_left_d;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [BIW-1:0]          byte_idx_q, byte_idx_d;
    logic                    dump_active_q, dump_active_d;
    logic                    dump_done_q, dump_done_d;

    logic                    wr_en_c;
    logic                    post_inc_c;
    logic                    post_last_c;
    logic                    pending_c;
    logic                    tx_en_c;
    logic [7:0]              tx_char_c;
    logic [EB-1:0][7:0]      padded_c;
    logic                    tx_ready;
    logic [CAPTURE_WIDTH_BITS-1:0] rd_data;

    // Event decode shared by the next-state and output processes.
    always_comb begin
        wr_en_c    = 1'b0;
        post_inc_c = 1'b0;
        tx_en_c    = 1'b0;
        pending_c  = (hdr_idx_q < 2'(HEADER_BYTES)) || (ent_left_q != 16'd0);
        case (state_q)
            CAPTURE: begin
                wr_en_c    = capture_enable;
                post_inc_c = capture_enable && trigger;
            end
            POST: begin
                wr_en_c    = capture_enable;
                post_inc_c = capture_enable;
            end
            DUMP:    tx_en_c = pending_c && tx_ready;
            default: ;
        endcase
        post_last_c = post_inc_c && ((post_cnt_q + PCW'(1)) == PCW'(POST_TRIGGER_ENTRIES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CAPTURE: if (trigger) state_d = post_last_c ? DUMP : POST;
            POST:    if (post_last_c) state_d = DUMP;
            DUMP:    if (!pending_c && tx_ready) state_d = DONE;
            DONE:    if (rearm) state_d = CAPTURE;
            default: state_d = CAPTURE;
        endcase
    end

    // Capture pointers, dump sequencer and registered status outputs.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        wrapped_d     = wrapped_q;
        post_cnt_d    = post_cnt_q;
        triggered_d   = triggered_q;
        rd_addr_d     = rd_addr_q;
        count_d       = count_q;
        ent_left_d    = ent_left_q;
        hdr_idx_d     = hdr_idx_q;
        byte_idx_d    = byte_idx_q;
        dump_active_d = (state_d == DUMP);
        dump_done_d   = (state_d == DONE);

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(CAPTURE_SIZE - 1)) begin
                wrapped_d = 1'b1;
            end
        end
        if (post_inc_c) begin
            post_cnt_d = post_cnt_q + PCW'(1);
        end
        if (state_q == CAPTURE && trigger) begin
            triggered_d = 1'b1;
        end

        // Latch the dump window from the pointers as they stand after the last write.
        if (post_last_c) begin
            rd_addr_d  = wrapped_d ? wr_ptr_d : '0;
            count_d    = wrapped_d ? 16'(CAPTURE_SIZE) : 16'(wr_ptr_d);
            ent_left_d = count_d;
            hdr_idx_d  = 2'd0;
            byte_idx_d = '0;
        end

        // Advance the read address once an entry's last byte is handed to the UART;
        // the registered read has a full byte time to settle.
        if (tx_en_c) begin
            if (hdr_idx_q < 2'(HEADER_BYTES)) begin
                hdr_idx_d = hdr_idx_q + 2'd1;
            end else if (byte_idx_q == BIW'(EB - 1)) begin
                byte_idx_d = '0;
                ent_left_d = ent_left_q - 16'd1;
                rd_addr_d  = rd_addr_q + AW'(1);
            end else begin
                byte_idx_d = byte_idx_q + BIW'(1);
            end
        end

        if (state_q == DONE && rearm) begin
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
        end
    end

    always_comb begin
        padded_c = PADW'(rd_data);
        case (hdr_idx_q)
            2'd0:    tx_char_c = FRAME_SYNC;
            2'd1:    tx_char_c = count_q[7:0];
            2'd2:    tx_char_c = count_q[15:8];
            default: tx_char_c = padded_c[byte_idx_q];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            wrapped_q     <= 1'b0;
            post_cnt_q    <= '0;
            triggered_q   <= 1'b0;
            rd_addr_q     <= '0;
            count_q       <= '0;
            ent_left_q    <= '0;
            hdr_idx_q     <= 2'(HEADER_BYTES);
            byte_idx_q    <= '0;
            dump_active_q <= 1'b0;
            dump_done_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wrapped_q     <= wrapped_d;
            post_cnt_q    <= post_cnt_d;
            triggered_q   <= triggered_d;
            rd_addr_q     <= rd_addr_d;
            count_q       <= count_d;
            ent_left_q    <= ent_left_d;
            hdr_idx_q     <= hdr_idx_d;
            byte_idx_q    <= byte_idx_d;
            dump_active_q <= dump_active_d;
            dump_done_q   <= dump_done_d;
        end
    end

    sram_1r1w #(
        .DATA_WIDTH (CAPTURE_WIDTH_BITS),
        .DEPTH      (CAPTURE_SIZE),
        .ADDR_WIDTH (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (capture_data),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    uart_transmit u_uart (
        .clk            (clk),
        .reset          (reset),
        .clocks_per_bit (12'(CLOCKS_PER_BIT)),
        .tx_en          (tx_en_c),
        .tx_char        (tx_char_c),
        .tx_ready       (tx_ready),
        .uart_tx        (uart_tx)
    );

    assign triggered   = triggered_q;
    assign dump_active = dump_active_q;
    assign dump_done   = dump_done_q;

endmodule

// File: tb/tb_trace_capture_uart.sv
// Directed bench: three analyzer configurations, frames decoded off uart_tx.
module tb_trace_capture_uart;

    localparam int BIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [31:0] cd_a, cd_b;
    logic [11:0] cd_c;
    logic        ce_a, ce_b, ce_c, trg_a, trg_b, trg_c, rr_a, rr_b, rr_c;
    logic        tx_a, tx_b, tx_c, tg_a, tg_b, tg_c, act_a, act_b, act_c, dn_a, dn_b, dn_c;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];

    trace_capture_uart #(.CAPTURE_WIDTH_BITS(32), .CAPTURE_SIZE(8), .POST_TRIGGER_ENTRIES(2),
                         .CLOCKS_PER_BIT(BIT)) dut_a (
        .clk(clk), .reset(reset), .capture_data(cd_a), .capture_enable(ce_a), .trigger(trg_a),
        .rearm(rr_a), .uart_tx(tx_a), .triggered(tg_a), .dump_active(act_a), .dump_done(dn_a));

    trace_capture_uart #(.CAPTURE_WIDTH_BITS(32), .CAPTURE_SIZE(8), .POST_TRIGGER_ENTRIES(3),
                         .CLOCKS_PER_BIT(BIT)) dut_b (
        .clk(clk), .reset(reset), .capture_data(cd_b), .capture_enable(ce_b), .trigger(trg_b),
        .rearm(rr_b), .uart_tx(tx_b), .triggered(tg_b), .dump_active(act_b), .dump_done(dn_b));

    trace_capture_uart #(.CAPTURE_WIDTH_BITS(12), .CAPTURE_SIZE(8), .POST_TRIGGER_ENTRIES(1),
                         .CLOCKS_PER_BIT(BIT)) dut_c (
        .clk(clk), .reset(reset), .capture_data(cd_c), .capture_enable(ce_c), .trigger(trg_c),
        .rearm(rr_c), .uart_tx(tx_c), .triggered(tg_c), .dump_active(act_c), .dump_done(dn_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int d);
        case (d)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    // {triggered, dump_active, dump_done}
    function automatic logic [2:0] st_of(input int d);
        case (d)
            0:       return {tg_a, act_a, dn_a};
            1:       return {tg_b, act_b, dn_b};
            default: return {tg_c, act_c, dn_c};
        endcase
    endfunction

    // Hold one set of inputs on DUT d for one clock; other DUTs see idle inputs.
    task automatic step(input int d, input logic en, input logic [31:0] v,
                        input logic trg, input logic rr);
        @(negedge clk);
        ce_a = 1'b0; ce_b = 1'b0; ce_c = 1'b0;
        trg_a = 1'b0; trg_b = 1'b0; trg_c = 1'b0;
        rr_a = 1'b0; rr_b = 1'b0; rr_c = 1'b0;
        case (d)
            0:       begin ce_a = en; cd_a = v;        trg_a = trg; rr_a = rr; end
            1:       begin ce_b = en; cd_b = v;        trg_b = trg; rr_b = rr; end
            default: begin ce_c = en; cd_c = v[11:0];  trg_c = trg; rr_c = rr; end
        endcase
    endtask

    task automatic wait_start(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx_of(d) == 1'b0) ok = 1'b1;
        end
    endtask

    task automatic rx_byte(input int d, output logic [7:0] b, output bit ok);
        b = '0;
        wait_start(d, ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = tx_of(d);
            end
            repeat (BIT) @(negedge clk);
            check_eq("stop_bit", 32'(tx_of(d)), 32'd1);
        end
    endtask

    task automatic push_hdr(input logic [15:0] c);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic push_ent(input logic [31:0] v, input int eb);
        for (int k = 0; k < eb; k++) exp_q.push_back(v[8*k +: 8]);
    endtask

    // Receive and compare the expected frame, then expect DONE.
    task automatic rx_frame(input int d, input string tag);
        logic [7:0] b;
        bit         ok;
        bit         stop;
        stop = 1'b0;
        for (int i = 0; i < exp_q.size() && !stop; i++) begin
            rx_byte(d, b, ok);
            if (!ok) begin
                check_eq({tag, "_timeout"}, 32'd0, 32'd1);
                stop = 1'b1;
            end else begin
                check_eq(tag, 32'(b), 32'(exp_q[i]));
            end
        end
        for (int i = 0; i < 20 && st_of(d)[0] !== 1'b1; i++) @(negedge clk);
        check_eq({tag, "_done"}, 32'(st_of(d)[0]), 32'd1);
        check_eq({tag, "_active_off"}, 32'(st_of(d)[1]), 32'd0);
        check_eq({tag, "_uart_idle"}, 32'(tx_of(d)), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [7:0] b;
        reset = 1'b1;
        cd_a = '0; cd_b = '0; cd_c = '0;
        ce_a = 1'b0; ce_b = 1'b0; ce_c = 1'b0;
        trg_a = 1'b0; trg_b = 1'b0; trg_c = 1'b0;
        rr_a = 1'b0; rr_b = 1'b0; rr_c = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_uart_tx", 32'(tx_a), 32'd1);
        check_eq("rst_status", 32'(st_of(0)), 32'd0);
        check_eq("rst_status_c", 32'(st_of(2)), 32'd0);
        reset = 1'b0;

        // Basic frame, with rearm pulses during DUMP that must be ignored.
        step(0, 1, 32'h11, 0, 0);
        step(0, 1, 32'h22, 0, 0);
        step(0, 1, 32'h33, 0, 0);
        step(0, 1, 32'h44, 1, 0);
        step(0, 1, 32'h55, 0, 0);
        check_eq("post_status", 32'(st_of(0)), 32'b100);
        step(0, 0, 32'h0, 0, 1);
        check_eq("dump_active", 32'(st_of(0)), 32'b110);
        step(0, 0, 32'h0, 0, 0);
        push_hdr(16'd5);
        push_ent(32'h11, 4); push_ent(32'h22, 4); push_ent(32'h33, 4);
        push_ent(32'h44, 4); push_ent(32'h55, 4);
        rx_frame(0, "basic");
        check_eq("trig_held", 32'(st_of(0)[2]), 32'd1);

        // Rearm from DONE: second frame carries only new samples.
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        check_eq("rearm_status", 32'(st_of(0)), 32'd0);
        step(0, 1, 32'hA1, 0, 0);
        step(0, 1, 32'hB2, 1, 0);
        step(0, 1, 32'hC3, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        push_hdr(16'd3);
        push_ent(32'hA1, 4); push_ent(32'hB2, 4); push_ent(32'hC3, 4);
        rx_frame(0, "rearm");

        // Reset during the second header byte, then a clean frame.
        step(0, 0, 32'h0, 0, 1);
        step(0, 1, 32'h01, 0, 0);
        step(0, 1, 32'h02, 1, 0);
        step(0, 1, 32'h03, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        rx_byte(0, b, ok);
        check_eq("rst_hdr0", 32'(b), 32'hA5);
        wait_start(0, ok);
        check_eq("rst_hdr1_seen", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_async_tx", 32'(tx_a), 32'd1);
        check_eq("rst_async_st", 32'(st_of(0)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 32'h77, 1, 0);
        step(0, 1, 32'h88, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        push_hdr(16'd2);
        push_ent(32'h77, 4); push_ent(32'h88, 4);
        rx_frame(0, "after_rst");

        // Wrapped buffer: 20 samples, trigger on 18, entries 13..20.
        for (int k = 1; k <= 20; k++) step(1, 1, 32'(k), k == 18, 0);
        step(1, 0, 32'h0, 0, 0);
        push_hdr(16'd8);
        for (int k = 13; k <= 20; k++) push_ent(32'(k), 4);
        rx_frame(1, "wrap");

        // Trigger with capture_enable low: trigger-cycle data absent.
        step(1, 0, 32'h0, 0, 1);
        step(1, 0, 32'hEE, 1, 0);
        step(1, 1, 32'h31, 0, 0);
        check_eq("trig_noen", 32'(st_of(1)), 32'b100);
        step(1, 1, 32'h32, 0, 0);
        step(1, 1, 32'h33, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        push_hdr(16'd3);
        push_ent(32'h31, 4); push_ent(32'h32, 4); push_ent(32'h33, 4);
        rx_frame(1, "noen");

        // 12-bit samples: two bytes per entry, upper pad bits zero.
        step(2, 1, 32'hFFFF_FABC, 1, 0);
        step(2, 0, 32'h0, 0, 0);
        push_hdr(16'd1);
        exp_q.push_back(8'hBC);
        exp_q.push_back(8'h0A);
        rx_frame(2, "w12");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
